// File: rtl/axi_wr_burst_packer.sv
// Write-path burst packer: buffers decompressed beats in a FIFO, slices the
// job into write bursts that respect MAX_BURST, the remaining job length and
// 4 KB boundaries, tracks outstanding responses and pulses done at the end.
module axi_wr_burst_packer #(
    parameter int ADDR_WIDTH      = 64,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_BURST       = 64,
    parameter int FIFO_DEPTH      = 128,
    parameter int REVERSE_BYTES   = 1,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   des_addr,
    input  logic [31:0]             decompression_length,
    output logic                    done,
    output logic                    idle,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic [DATA_WIDTH/8-1:0] byte_valid_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic                    wr_req,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic [7:0]              wr_len,
    input  logic                    wr_req_ack,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_data_strobe,
    output logic                    wr_valid,
    input  logic                    wr_ready,
    output logic                    wr_data_last,
    output logic                    bready,
    input  logic                    wr_done
);

    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int BSHIFT  = $clog2(BYTES);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int ENTRY_W = DATA_WIDTH + BYTES;

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_REQ, S_DATA, S_DRAIN, S_FIN
    } state_t;

    state_t                state_q, state_d;
    logic [32:0]           total_beats_q, total_beats_d;
    logic [32:0]           accepted_q, accepted_d;
    logic [32:0]           remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [8:0]            burst_q, burst_d;
    logic                  calc_done_q, calc_done_d;
    logic [8:0]            beat_cnt_q, beat_cnt_d;
    logic [OUT_W-1:0]      outstanding_q, outstanding_d;
    logic                  wr_req_q, wr_req_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_len_q, wr_len_d;
    logic                  done_q, done_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [ENTRY_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]    rd_entry_q;
    logic [ENTRY_W-1:0]    wr_entry;

    logic                  fifo_empty, fifo_full;
    logic                  push, pop, last_hs;
    logic [32:0]           total_calc;
    logic [12:0]           room_bytes;
    logic [32:0]           room_beats, burst_min;
    logic [8:0]            burst_calc;
    logic [DATA_WIDTH-1:0] head_data;
    logic [BYTES-1:0]      head_strb;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign ready_out  = (state_q != S_IDLE) && !fifo_full && (accepted_q < total_beats_q);
    assign push       = valid_in && ready_out;
    assign wr_valid   = (state_q == S_DATA) && !fifo_empty;
    assign pop        = wr_valid && wr_ready;
    assign last_hs    = pop && (beat_cnt_q == burst_q - 9'd1);
    assign wr_data_last = wr_valid && (beat_cnt_q == burst_q - 9'd1);
    assign wr_entry   = {data_in, byte_valid_in};
    assign total_calc = ({1'b0, decompression_length} + 33'(BYTES - 1)) >> BSHIFT;

    assign done    = done_q;
    assign idle    = (state_q == S_IDLE);
    assign bready  = (state_q != S_IDLE);
    assign wr_req  = wr_req_q;
    assign wr_addr = wr_addr_q;
    assign wr_len  = wr_len_q;

    // Burst size: smallest of the configured cap, the beats still to request
    // and the beats left before the next 4 KB page.
    always_comb begin
        room_bytes = 13'd4096 - {1'b0, next_addr_q[11:0]};
        room_beats = 33'(room_bytes >> BSHIFT);
        burst_min  = 33'(MAX_BURST);
        if (remaining_q < burst_min) begin
            burst_min = remaining_q;
        end
        if (room_beats < burst_min) begin
            burst_min = room_beats;
        end
        burst_calc = 9'(burst_min);
    end

    // Next-state logic for the job FSM, FIFO pointers and response counter.
    always_comb begin
        state_d       = state_q;
        total_beats_d = total_beats_q;
        accepted_d    = accepted_q;
        remaining_d   = remaining_q;
        next_addr_d   = next_addr_q;
        burst_d       = burst_q;
        calc_done_d   = calc_done_q;
        beat_cnt_d    = beat_cnt_q;
        wr_req_d      = wr_req_q;
        wr_addr_d     = wr_addr_q;
        wr_len_d      = wr_len_q;
        done_d        = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    total_beats_d = total_calc;
                    remaining_d   = total_calc;
                    accepted_d    = '0;
                    next_addr_d   = des_addr;
                    calc_done_d   = 1'b0;
                    beat_cnt_d    = '0;
                    state_d       = (total_calc == '0) ? S_FIN : S_CALC;
                end
            end
            S_CALC: begin
                if (remaining_q == '0) begin
                    state_d = S_DRAIN;
                end else if (!calc_done_q) begin
                    burst_d     = burst_calc;
                    calc_done_d = 1'b1;
                end else if ((33'(count_q) >= 33'(burst_q)) &&
                             (outstanding_q < OUT_W'(MAX_OUTSTANDING))) begin
                    wr_req_d  = 1'b1;
                    wr_addr_d = next_addr_q;
                    wr_len_d  = 8'(burst_q - 9'd1);
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (wr_req_ack) begin
                    wr_req_d    = 1'b0;
                    next_addr_d = next_addr_q + (ADDR_WIDTH'(burst_q) << BSHIFT);
                    remaining_d = remaining_q - 33'(burst_q);
                    beat_cnt_d  = '0;
                    state_d     = S_DATA;
                end
            end
            S_DATA: begin
                if (last_hs) begin
                    beat_cnt_d  = '0;
                    calc_done_d = 1'b0;
                    state_d     = S_CALC;
                end else if (pop) begin
                    beat_cnt_d = beat_cnt_q + 9'd1;
                end
            end
            S_DRAIN: begin
                if (outstanding_q == '0) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            accepted_d = accepted_q + 33'd1;
        end

        // A spurious response with nothing outstanding is dropped.
        outstanding_d = outstanding_q;
        if (last_hs && !(wr_done && outstanding_q != '0)) begin
            outstanding_d = outstanding_q + OUT_W'(1);
        end else if (!last_hs && wr_done && outstanding_q != '0) begin
            outstanding_d = outstanding_q - OUT_W'(1);
        end

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            total_beats_q <= '0;
            accepted_q    <= '0;
            remaining_q   <= '0;
            next_addr_q   <= '0;
            burst_q       <= '0;
            calc_done_q   <= 1'b0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            wr_req_q      <= 1'b0;
            wr_addr_q     <= '0;
            wr_len_q      <= '0;
            done_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            total_beats_q <= total_beats_d;
            accepted_q    <= accepted_d;
            remaining_q   <= remaining_d;
            next_addr_q   <= next_addr_d;
            burst_q       <= burst_d;
            calc_done_q   <= calc_done_d;
            beat_cnt_q    <= beat_cnt_d;
            outstanding_q <= outstanding_d;
            wr_req_q      <= wr_req_d;
            wr_addr_q     <= wr_addr_d;
            wr_len_q      <= wr_len_d;
            done_q        <= done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // Beat storage with registered read of the next head; a write landing on
    // the address being fetched is forwarded so the head is never stale.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
        if (push && (wr_ptr_q == rd_ptr_d)) begin
            rd_entry_q <= wr_entry;
        end else begin
            rd_entry_q <= mem_q[rd_ptr_d];
        end
    end

    assign head_data = rd_entry_q[ENTRY_W-1:BYTES];
    assign head_strb = rd_entry_q[BYTES-1:0];

    // Byte lane mapping toward the write channel (data and strobe together).
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        localparam int SRC = (REVERSE_BYTES != 0) ? (BYTES - 1 - gi) : gi;
        assign wr_data[gi*8 +: 8]  = head_data[SRC*8 +: 8];
        assign wr_data_strobe[gi]  = head_strb[SRC];
    end

endmodule
